// File: rtl/ysyx_22040386_clint_pkg.sv
// Shared constants for the core-local interruptor: register offsets inside
// the CLINT region and the mtimecmp reset value.
package ysyx_22040386_clint_pkg;

  localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  // All ones keeps mtime >= mtimecmp false out of reset, so no stray interrupt.
  localparam logic [63:0] MTIMECMP_RST       = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/ysyx_22040386_clint_tick.sv
// mtime prescaler: emits a one-cycle tick strobe every TICK_DIV cycles.
// With TICK_DIV == 1 every cycle is a tick and no counter exists.
module ysyx_22040386_clint_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  generate
    if (TICK_DIV == 1) begin : g_nodiv
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;
      assign o_tick = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(TICK_DIV);
      localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Count 0..TICK_DIV-1 and wrap; the last count is the tick cycle.
      always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) cnt_d = '0;
      end

      // Prescaler register.
      always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign o_tick = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/ysyx_22040386_clint.sv
// Core-local interruptor: mtime / mtimecmp responder for MEM-stage accesses
// and machine timer interrupt pending generation.
// Optional msip register enabled by defining YSYX_22040386_CLINT_MSIP_EN.
module ysyx_22040386_clint
  import ysyx_22040386_clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        i_CLINT_clk,
  input  logic        i_CLINT_rst,
  input  logic        i_CLINT_ren,
  input  logic        i_CLINT_wen,
  input  logic [63:0] i_CLINT_addr,
  input  logic [63:0] i_CLINT_wdata,
  input  logic [7:0]  i_CLINT_wmask,
  output logic        o_CLINT_hit,
  output logic [63:0] o_CLINT_rdata,
  output logic        o_CLINT_mtip
`ifdef YSYX_22040386_CLINT_MSIP_EN
  ,output logic       o_CLINT_msip
`endif
);

  // Doubleword-granular addresses; the byte offset within a doubleword is
  // handled by the MEM unit's lane logic.
  localparam logic [60:0] MTIME_DW    = 61'((BASE_ADDR + CLINT_MTIME_OFF) >> 3);
  localparam logic [60:0] MTIMECMP_DW = 61'((BASE_ADDR + CLINT_MTIMECMP_OFF) >> 3);

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  mask);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{mask[b]}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic        tick;
  logic        sel_mtime;
  logic        sel_cmp;
  logic        sel_msip;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q, mtip_d;
  logic        unused_addr;

  assign unused_addr = ^i_CLINT_addr[2:0];

  ysyx_22040386_clint_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk  (i_CLINT_clk),
    .i_rst  (i_CLINT_rst),
    .o_tick (tick)
  );

  assign sel_mtime = (i_CLINT_addr[63:3] == MTIME_DW);
  assign sel_cmp   = (i_CLINT_addr[63:3] == MTIMECMP_DW);

`ifdef YSYX_22040386_CLINT_MSIP_EN
  localparam logic [60:0] MSIP_DW = 61'((BASE_ADDR + CLINT_MSIP_OFF) >> 3);
  logic msip_q, msip_d;

  assign sel_msip     = (i_CLINT_addr[63:3] == MSIP_DW);
  assign o_CLINT_msip = msip_q;

  // Software interrupt bit: only lane 0, bit 0 is writable.
  always_comb begin
    msip_d = msip_q;
    if (i_CLINT_wen && sel_msip && i_CLINT_wmask[0]) msip_d = i_CLINT_wdata[0];
  end

  // msip register.
  always_ff @(posedge i_CLINT_clk) begin
    if (i_CLINT_rst) msip_q <= 1'b0;
    else             msip_q <= msip_d;
  end
`else
  assign sel_msip = 1'b0;
`endif

  assign o_CLINT_hit  = sel_mtime | sel_cmp | sel_msip;
  assign o_CLINT_mtip = mtip_q;

  // Next-state: a store beats a same-cycle tick; mtip compares current values.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (i_CLINT_wen && sel_mtime)
      mtime_d = merge_bytes(mtime_q, i_CLINT_wdata, i_CLINT_wmask);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
    if (i_CLINT_wen && sel_cmp)
      mtimecmp_d = merge_bytes(mtimecmp_q, i_CLINT_wdata, i_CLINT_wmask);
    mtip_d = (mtime_q >= mtimecmp_q);
  end

  // Timer state registers.
  always_ff @(posedge i_CLINT_clk) begin
    if (i_CLINT_rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
    end
  end

  // Same-cycle read mux; returns pre-write values and zero when not reading.
  always_comb begin
    o_CLINT_rdata = 64'd0;
    if (i_CLINT_ren) begin
      if (sel_mtime)    o_CLINT_rdata = mtime_q;
      else if (sel_cmp) o_CLINT_rdata = mtimecmp_q;
`ifdef YSYX_22040386_CLINT_MSIP_EN
      else if (sel_msip) o_CLINT_rdata = {63'd0, msip_q};
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_clint.sv
// Bench for ysyx_22040386_clint: two instances (TICK_DIV=1 and TICK_DIV=4)
// share one stimulus stream and are compared against a reference model.
module tb_ysyx_22040386_clint;

  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_MSIP  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_NONE  = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic [7:0]  wmask = 8'd0;

  logic        hit1, hit4, mtip1, mtip4;
  logic [63:0] rdata1, rdata4;
`ifdef YSYX_22040386_CLINT_MSIP_EN
  logic        msip1, msip4;
`endif

  always #5 clk = ~clk;

  ysyx_22040386_clint #(.TICK_DIV(1)) dut1 (
    .i_CLINT_clk(clk), .i_CLINT_rst(rst), .i_CLINT_ren(ren), .i_CLINT_wen(wen),
    .i_CLINT_addr(addr), .i_CLINT_wdata(wdata), .i_CLINT_wmask(wmask),
    .o_CLINT_hit(hit1), .o_CLINT_rdata(rdata1), .o_CLINT_mtip(mtip1)
`ifdef YSYX_22040386_CLINT_MSIP_EN
    , .o_CLINT_msip(msip1)
`endif
  );

  ysyx_22040386_clint #(.TICK_DIV(4)) dut4 (
    .i_CLINT_clk(clk), .i_CLINT_rst(rst), .i_CLINT_ren(ren), .i_CLINT_wen(wen),
    .i_CLINT_addr(addr), .i_CLINT_wdata(wdata), .i_CLINT_wmask(wmask),
    .o_CLINT_hit(hit4), .o_CLINT_rdata(rdata4), .o_CLINT_mtip(mtip4)
`ifdef YSYX_22040386_CLINT_MSIP_EN
    , .o_CLINT_msip(msip4)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state, index 0 -> TICK_DIV=1, index 1 -> TICK_DIV=4.
  logic [63:0] m_mt[2];
  logic [63:0] m_cmp[2];
  logic        m_mtip[2];
  logic        m_msip[2];
  longint      m_cyc[2];
  int          divs[2] = '{1, 4};

  // Samples of the combinational outputs taken during the last step.
  logic        s_hit1, s_hit4;
  logic [63:0] s_rd1, s_rd4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 0 none, 1 mtimecmp, 2 mtime, 3 msip
  function automatic int decode(input logic [63:0] a);
    logic [63:0] al;
    al = a & ~64'h7;
    if (al == A_MTIME) return 2;
    if (al == A_CMP) return 1;
`ifdef YSYX_22040386_CLINT_MSIP_EN
    if (al == A_MSIP) return 3;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_rd(input int i, input logic r, input logic [63:0] a);
    int d;
    d = decode(a);
    if (!r) return 64'd0;
    case (d)
      1: return m_cmp[i];
      2: return m_mt[i];
      3: return {63'd0, m_msip[i]};
      default: return 64'd0;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, advance model, check registered outputs.
  task automatic step(input logic r_rst, input logic r_ren, input logic r_wen,
                      input logic [63:0] r_addr, input logic [63:0] r_wd, input logic [7:0] r_wm);
    int d;
    logic nt, tk;
    @(negedge clk);
    rst = r_rst; ren = r_ren; wen = r_wen; addr = r_addr; wdata = r_wd; wmask = r_wm;
    #1;
    s_hit1 = hit1; s_hit4 = hit4; s_rd1 = rdata1; s_rd4 = rdata4;
    d = decode(r_addr);
    if (!r_rst) begin
      chk("hit1", {63'd0, hit1}, {63'd0, d != 0});
      chk("hit4", {63'd0, hit4}, {63'd0, d != 0});
      chk("rdata1", rdata1, exp_rd(0, r_ren, r_addr));
      chk("rdata4", rdata4, exp_rd(1, r_ren, r_addr));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r_rst) begin
        m_mt[i] = 64'd0; m_cmp[i] = '1; m_mtip[i] = 1'b0; m_msip[i] = 1'b0; m_cyc[i] = 0;
      end else begin
        nt = (m_mt[i] >= m_cmp[i]);
        tk = ((m_cyc[i] % divs[i]) == longint'(divs[i] - 1));
        m_cyc[i]++;
        if (r_wen && d == 2) m_mt[i] = merge(m_mt[i], r_wd, r_wm);
        else if (tk) m_mt[i] = m_mt[i] + 64'd1;
        if (r_wen && d == 1) m_cmp[i] = merge(m_cmp[i], r_wd, r_wm);
        if (r_wen && d == 3 && r_wm[0]) m_msip[i] = r_wd[0];
        m_mtip[i] = nt;
      end
    end
    #1;
    chk("mtip1", {63'd0, mtip1}, {63'd0, m_mtip[0]});
    chk("mtip4", {63'd0, mtip4}, {63'd0, m_mtip[1]});
`ifdef YSYX_22040386_CLINT_MSIP_EN
    chk("msip1", {63'd0, msip1}, {63'd0, m_msip[0]});
    chk("msip4", {63'd0, msip4}, {63'd0, m_msip[1]});
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
  endtask

  typedef struct {
    logic [63:0] a;
    logic        ren;
    logic        exp_hit;
  } dec_vec_t;

  dec_vec_t dv[10];

  initial begin
`ifdef YSYX_22040386_CLINT_MSIP_EN
    logic msip_hit = 1'b1;
`else
    logic msip_hit = 1'b0;
`endif
    logic [63:0] ad;
    int sel;

    dv[0] = '{A_MTIME,            1'b1, 1'b1};
    dv[1] = '{A_MTIME + 64'd7,    1'b1, 1'b1};
    dv[2] = '{A_MTIME - 64'd8,    1'b1, 1'b0};
    dv[3] = '{A_CMP,              1'b1, 1'b1};
    dv[4] = '{A_CMP + 64'd5,      1'b0, 1'b1};
    dv[5] = '{A_CMP + 64'd8,      1'b1, 1'b0};
    dv[6] = '{A_NONE,             1'b1, 1'b0};
    dv[7] = '{A_MSIP,             1'b1, msip_hit};
    dv[8] = '{A_MTIME + 64'h1_0000_0000, 1'b1, 1'b0};
    dv[9] = '{A_MTIME,            1'b0, 1'b1};

    // Reset state.
    do_reset();
    step(1'b0, 1'b1, 1'b0, A_CMP, 64'd0, 8'd0);
    chk("rst_cmp", s_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mtip", {63'd0, mtip1}, 64'd0);

    // Decode table.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, dv[i].ren, 1'b0, dv[i].a, 64'd0, 8'd0);
      chk("tbl_hit", {63'd0, s_hit1}, {63'd0, dv[i].exp_hit});
      if (!dv[i].ren || !dv[i].exp_hit) chk("tbl_rd0", s_rd4, 64'd0);
    end

    // Count 10 cycles, TICK_DIV=4 case, store on tick cycle.
    do_reset();
    idle(10);
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);        // cycle 10
    chk("cnt10_rd", s_rd1, 64'd10);
    chk("cnt10_hit", {63'd0, s_hit1}, 64'd1);
    chk("cnt10_mtip", {63'd0, mtip1}, 64'd0);
    idle(1);                                             // cycle 11
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);        // cycle 12
    chk("div4_rd12", s_rd4, 64'd3);
    idle(2);                                             // cycles 13,14
    step(1'b0, 1'b0, 1'b1, A_MTIME, 64'd100, 8'hFF);     // cycle 15, tick
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);
    chk("div4_st_over_tick", s_rd4, 64'd100);
    chk("div1_st_over_tick", s_rd1, 64'd100);

    // mtip rise and fall.
    do_reset();
    idle(5);
    step(1'b0, 1'b0, 1'b1, A_CMP, 64'd20, 8'hFF);        // cycle 5, mtime=5
    idle(14);                                            // cycles 6..19
    chk("mtip_before", {63'd0, mtip1}, 64'd0);
    idle(1);                                             // cycle 20
    chk("mtip_rise", {63'd0, mtip1}, 64'd1);
    step(1'b0, 1'b0, 1'b1, A_CMP, 64'd1000, 8'hFF);      // cycle 21
    chk("mtip_hold", {63'd0, mtip1}, 64'd1);
    idle(1);
    chk("mtip_fall", {63'd0, mtip1}, 64'd0);

    // Byte-masked store into mtimecmp, plus read-during-write.
    do_reset();
    step(1'b0, 1'b1, 1'b1, A_CMP, 64'h0000_0000_0000_00AB, 8'h01);
    chk("rw_prewrite", s_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, A_CMP, 64'd0, 8'd0);
    chk("cmp_bytemask", s_rd1, 64'hFFFF_FFFF_FFFF_FFAB);

    // mtime wrap.
    step(1'b0, 1'b0, 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);
    chk("wrap_fe", s_rd1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);
    chk("wrap_ff", s_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, A_MTIME, 64'd0, 8'd0);
    chk("wrap_00", s_rd1, 64'd0);

    // Out-of-region access.
    step(1'b0, 1'b1, 1'b0, A_NONE, 64'd0, 8'd0);
    chk("none_hit", {63'd0, s_hit1}, 64'd0);
    chk("none_rd", s_rd1, 64'd0);
    step(1'b0, 1'b0, 1'b1, A_NONE, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    step(1'b0, 1'b1, 1'b0, A_CMP, 64'd0, 8'd0);
    chk("none_cmp_kept", s_rd1, 64'hFFFF_FFFF_FFFF_FFAB);

`ifdef YSYX_22040386_CLINT_MSIP_EN
    step(1'b0, 1'b0, 1'b1, A_MSIP, 64'd1, 8'h01);
    chk("msip_set", {63'd0, msip1}, 64'd1);
    step(1'b0, 1'b1, 1'b0, A_MSIP, 64'd0, 8'd0);
    chk("msip_rd", s_rd1, 64'd1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: ad = A_MTIME;
        1: ad = A_MTIME + 64'($urandom_range(1, 7));
        2: ad = A_CMP;
        3: ad = A_CMP + 64'($urandom_range(1, 7));
        4: ad = A_MSIP;
        5: ad = A_NONE;
        6: ad = A_CMP + 64'd8;
        default: ad = {$urandom, $urandom};
      endcase
      step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom), ad,
           ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 400)) : {$urandom, $urandom},
           ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040386_clint.md
# ysyx_22040386_clint

Core-local interruptor (CLINT) acting as the responder for MEM-stage accesses to the timer region. It holds the free-running 64-bit `mtime` counter and the `mtimecmp` compare register, serves loads and stores addressed to them, and drives the machine timer interrupt pending line toward the CSR unit. It sits beside the memory access unit: that unit suppresses its own DPI writes to `0x200_BFF8` and `0x200_4000`, and this block absorbs those writes.

## Interface
Parameters:
- `BASE_ADDR`, default `64'h0000_0000_0200_0000`: CLINT region base.
- `TICK_DIV`, default `1`: core cycles per `mtime` increment. Must be ≥1.

Ports:
- `i_CLINT_clk`, input, 1: the block's single clock.
- `i_CLINT_rst`, input, 1: reset, synchronous, active-high.
- `i_CLINT_ren`, input, 1: load request this cycle.
- `i_CLINT_wen`, input, 1: store request this cycle.
- `i_CLINT_addr`, input, 64: byte address, the MEM-stage ALU result.
- `i_CLINT_wdata`, input, 64: store data, already lane-aligned.
- `i_CLINT_wmask`, input, 8: byte-enable for the store.
- `o_CLINT_hit`, output, 1: address decodes to a CLINT register. Combinational.
- `o_CLINT_rdata`, output, 64: full doubleword read data. Combinational.
- `o_CLINT_mtip`, output, 1: machine timer interrupt pending. Registered.

## Operation
- Decode uses `addr[63:3]`; `addr[2:0]` is ignored. The MEM unit performs byte and halfword lane extraction, and wmask selects the lanes written.
  - `mtimecmp` at `BASE_ADDR+0x4000`.
  - `mtime` at `BASE_ADDR+0xBFF8`.
- No hit:
  - `o_CLINT_hit=0` and `o_CLINT_rdata=0`.
  - Stores are ignored.
- Read:
  - When `ren` is high and the address hits, `rdata` is the current register value.
  - When `ren` is low, `rdata` is 0.
- Prescaler: a counter of width `$clog2(TICK_DIV)` counts 0..TICK_DIV-1 and wraps.
  - A tick occurs when the counter equals TICK_DIV-1.
  - With `TICK_DIV==1`, every cycle is a tick and no counter is built.
- `mtime`:
  - On a tick, `mtime <= mtime+1`, mod 2^64. `FFFF_FFFF_FFFF_FFFF` wraps to 0.
  - On a store hit, `mtime <= (mtime & ~M) | (wdata & M)`, where M is wmask expanded to bytes.
  - A store overrides a same-cycle tick, so that increment is lost.
  - A store does not reset the prescaler.
- `mtimecmp`: byte-masked write, same rule as `mtime`. It has no other update.
- `o_CLINT_mtip <= (mtime >= mtimecmp)`, an unsigned compare evaluated on the current-cycle register values.
- `ren` and `wen` both high at a hit: `rdata` returns the pre-write value, and the write applies at the clock edge.
- Reset values:
  - `mtime=0`.
  - `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, so no spurious interrupt occurs.
  - Prescaler 0.
  - `o_CLINT_mtip=0`.
- Reset wins over every same-cycle store or tick.

## Timing
- Read latency is 0 cycles, combinational, matching the MEM unit's same-cycle DPI read.
- Write takes effect at the rising edge ending the request cycle.
- Update of `mtip`:
  - Changes one cycle after the register values change.
  - A store to `mtimecmp` in cycle N is reflected in `mtip` at the end of cycle N+1.
- First `mtime` increment after reset: at the edge ending cycle TICK_DIV-1 after reset deasserts. The first cycle with reset low is cycle 0.
- No handshake or stall exists. Every request completes in one cycle.

## Configuration
- `YSYX_22040386_CLINT_MSIP_EN`.
- Defined:
  - Adds a 1-bit `msip` register at `BASE_ADDR+0x0`, writable through `wdata[0]` when `wmask[0]` is set.
  - Reads return `{63'b0, msip}`.
  - Adds output `o_CLINT_msip`, 1 bit, equal to the registered `msip`. It resets to 0.
- Undefined:
  - Offset 0x0 does not hit.
  - No `o_CLINT_msip` port exists.

## Structure
- Shared package `ysyx_22040386_clint_pkg` holds:
  - Offset constants `CLINT_MSIP_OFF=0x0`, `CLINT_MTIMECMP_OFF=0x4000`, `CLINT_MTIME_OFF=0xBFF8`.
  - The `mtimecmp` reset constant.
- One sub-module, `ysyx_22040386_clint_tick`: the prescaler, which outputs a 1-bit `tick` strobe.
- The byte-mask merge is a local function.

## Test plan
- Reset, TICK_DIV=1, read `0x200_BFF8` after 10 cycles -> `rdata=10`, `mtip=0`, `hit=1`.
- TICK_DIV=4: 12 cycles after reset -> `mtime=3`. A store to `mtime` with `wdata=100` and `wmask=FF` on the tick cycle -> next read is 100, not 101.
- Store `mtimecmp=20` with mtime at 5 -> `mtip` rises exactly one cycle after `mtime` reaches 20. A later store `mtimecmp=1000` -> `mtip` falls the following cycle.
- Store `wdata=0xAB` with `wmask=0x01` to `mtimecmp` after reset -> reads `FFFF_FFFF_FFFF_FFAB`.
- Store `mtime=FFFF_FFFF_FFFF_FFFE` with TICK_DIV=1 -> reads FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, then 0 on successive cycles.
- Read `0x8000_0000` -> `hit=0` and `rdata=0`; a store there leaves both registers unchanged. With MSIP_EN, store 1 to `0x200_0000` -> `o_CLINT_msip=1` next cycle.
